// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory arbiter: FSM encodings and
// the largest IROM read latency the wait counter is sized for.
package imem_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT    = 2'd2,
        DELIVER = 2'd3
    } imem_state_t;

    localparam int ROM_LAT_MAX = 4;

endpackage

// File: rtl/imem_arbiter_if.sv
// Core-array and IROM signals of the instruction-memory arbiter.
// The arbiter takes the slave modport; the core array/IROM side takes the master modport.
interface imem_arbiter_if #(
    parameter int NCORES = 4,
    parameter int AW     = 8,
    parameter int DW     = 8
);

    logic [NCORES-1:0]    core_req;
    logic [NCORES-1:0]    core_halt;
    logic [NCORES*AW-1:0] core_pc;
    logic [DW-1:0]        rom_data;
    logic                 rom_en;
    logic [AW-1:0]        rom_addr;
    logic [NCORES*DW-1:0] core_ins;
    logic [NCORES-1:0]    core_av;
    logic                 busy;

    modport slave (
        input  core_req, core_halt, core_pc, rom_data,
        output rom_en, rom_addr, core_ins, core_av, busy
    );

    modport master (
        output core_req, core_halt, core_pc, rom_data,
        input  rom_en, rom_addr, core_ins, core_av, busy
    );

endinterface

// File: rtl/rr_pick.sv
// Round-robin first-set-bit finder: returns the first set bit of mask found by
// searching upward from ptr and wrapping around at N.
module rr_pick #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  mask,
    input  logic [PW-1:0] ptr,
    output logic [PW-1:0] idx,
    output logic          found
);

    logic [PW:0] j;

    // Walk from the farthest candidate back to ptr so the nearest set bit wins.
    always_comb begin
        idx   = '0;
        found = |mask;
        j     = '0;
        for (int k = N - 1; k >= 0; k--) begin
            j = {1'b0, ptr} + (PW+1)'(k);
            if (j >= (PW+1)'(N)) begin
                j = j - (PW+1)'(N);
            end
            if (mask[j[PW-1:0]]) begin
                idx = j[PW-1:0];
            end
        end
    end

endmodule

// File: rtl/imem_arbiter.sv
// Shares one single-port IROM among NCORES cores: identical-PC requests are merged
// into one broadcast fetch, and divergent PCs are served in round-robin order.
//
// state   | meaning
// IDLE    | waiting for the issue condition; leader, grant mask and address latched here
// ISSUE   | rom_en pulse ends; wait counter loaded with ROM_LAT-1
// WAIT    | down-counting the remaining IROM latency
// DELIVER | rom_data written to granted slots, core_av pulsed, rr_ptr advanced
module imem_arbiter
    import imem_pkg::*;
#(
    parameter int NCORES   = 4,
    parameter int AW       = 8,
    parameter int DW       = 8,
    parameter int ROM_LAT  = 1,
    parameter int LOCKSTEP = 1
) (
    input  logic           Clk,
    input  logic           Rst_n,
    imem_arbiter_if.slave  bus
);

    localparam int PW = $clog2(NCORES);
    localparam int CW = $clog2(ROM_LAT_MAX);

    imem_state_t          state;
    logic [PW-1:0]        rr_ptr;
    logic [PW-1:0]        leader;
    logic [NCORES-1:0]    grant;
    logic [CW-1:0]        cnt;
    logic                 rom_en_q;
    logic [AW-1:0]        rom_addr_q;
    logic [NCORES*DW-1:0] core_ins_q;
    logic [NCORES-1:0]    core_av_q;

    logic [NCORES-1:0]    active;
    logic [NCORES-1:0]    match;
    logic [AW-1:0]        pc [NCORES];
    logic [AW-1:0]        leader_pc;
    logic [PW-1:0]        pick_idx;
    logic                 pick_found;
    logic                 issue;

    assign active = bus.core_req & ~bus.core_halt;

    rr_pick #(
        .N  (NCORES),
        .PW (PW)
    ) u_rr_pick (
        .mask  (active),
        .ptr   (rr_ptr),
        .idx   (pick_idx),
        .found (pick_found)
    );

    always_comb begin
        for (int i = 0; i < NCORES; i++) begin
            pc[i] = bus.core_pc[i*AW +: AW];
        end
    end

    assign leader_pc = pc[pick_idx];

    // Every active core sitting on the leader's PC joins the broadcast fetch.
    always_comb begin
        match = '0;
        for (int i = 0; i < NCORES; i++) begin
            match[i] = active[i] && (pc[i] == leader_pc);
        end
    end

    generate
        if (LOCKSTEP != 0) begin : g_lockstep
            assign issue = pick_found && (active == ~bus.core_halt) && (|(~bus.core_halt));
        end else begin : g_free
            assign issue = pick_found;
        end
    endgenerate

    always_ff @(negedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            leader     <= '0;
            grant      <= '0;
            cnt        <= '0;
            rom_en_q   <= 1'b0;
            rom_addr_q <= '0;
            core_ins_q <= '0;
            core_av_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    core_av_q <= '0;
                    rom_en_q  <= 1'b0;
                    if (issue) begin
                        leader     <= pick_idx;
                        grant      <= match;
                        rom_addr_q <= leader_pc;
                        rom_en_q   <= 1'b1;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    rom_en_q <= 1'b0;
                    cnt      <= CW'(ROM_LAT - 1);
                    state    <= (ROM_LAT == 1) ? DELIVER : WAIT;
                end
                WAIT: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        state <= DELIVER;
                    end
                end
                DELIVER: begin
                    // A core halted mid-fetch still gets its slot written, just no pulse.
                    for (int i = 0; i < NCORES; i++) begin
                        if (grant[i]) begin
                            core_ins_q[i*DW +: DW] <= bus.rom_data;
                        end
                    end
                    core_av_q <= grant & ~bus.core_halt;
                    rr_ptr    <= (leader == PW'(NCORES - 1)) ? '0 : leader + PW'(1);
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.rom_en   = rom_en_q;
    assign bus.rom_addr = rom_addr_q;
    assign bus.core_ins = core_ins_q;
    assign bus.core_av  = core_av_q;
    assign bus.busy     = (state != IDLE);

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter: a lockstep/latency-1 instance and a free-running/latency-3 instance.
module tb_imem_arbiter;

    logic Clk     = 1'b1;
    logic rst_n_a = 1'b0;
    logic rst_n_b = 1'b0;

    int n_chk    = 0;
    int n_err    = 0;
    int en_cnt_a = 0;
    int en_cnt_b = 0;
    logic [31:0] exp_ins_b = '0;

    always #5 Clk = ~Clk;

    imem_arbiter_if #(.NCORES(4), .AW(8), .DW(8)) ia ();
    imem_arbiter_if #(.NCORES(4), .AW(8), .DW(8)) ib ();

    assign ia.rom_data = ia.rom_addr ^ 8'hB5;
    assign ib.rom_data = ib.rom_addr ^ 8'hB5;

    imem_arbiter #(.NCORES(4), .AW(8), .DW(8), .ROM_LAT(1), .LOCKSTEP(1)) dut_a (
        .Clk   (Clk),
        .Rst_n (rst_n_a),
        .bus   (ia)
    );

    imem_arbiter #(.NCORES(4), .AW(8), .DW(8), .ROM_LAT(3), .LOCKSTEP(0)) dut_b (
        .Clk   (Clk),
        .Rst_n (rst_n_b),
        .bus   (ib)
    );

    always @(posedge Clk) begin
        if (ia.rom_en === 1'b1) en_cnt_a <= en_cnt_a + 1;
        if (ib.rom_en === 1'b1) en_cnt_b <= en_cnt_b + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One fetch on dut_b: rom_en/address, ROM_LAT+1 latency, busy span, av pattern, slot data.
    task automatic fetch_b(input string tag, input logic [7:0] addr, input logic [3:0] av);
        int   n;
        int   busy_n;
        int   en0;
        logic seen;
        en0    = en_cnt_b;
        seen   = 1'b0;
        n      = 0;
        while (!seen && n < 20) begin
            tick;
            seen = ib.rom_en;
            n++;
        end
        chk({tag, " issue"}, 32'(seen), 32'd1);
        chk({tag, " addr"}, 32'(ib.rom_addr), 32'(addr));
        busy_n = 0;
        n      = 0;
        while (ib.core_av == 4'b0000 && n < 20) begin
            if (ib.busy) busy_n++;
            tick;
            n++;
        end
        chk({tag, " latency"}, 32'(n), 32'd4);
        chk({tag, " busy span"}, 32'(busy_n), 32'd4);
        chk({tag, " av"}, 32'(ib.core_av), 32'(av));
        for (int i = 0; i < 4; i++) begin
            if (av[i]) exp_ins_b[i*8 +: 8] = addr ^ 8'hB5;
        end
        chk({tag, " ins"}, ib.core_ins, exp_ins_b);
        chk({tag, " en count"}, 32'(en_cnt_b - en0), 32'd1);
        ib.core_req = ib.core_req & ~av;
    endtask

    initial begin
        int n;
        ia.core_req  = '0;
        ia.core_halt = '0;
        ia.core_pc   = '0;
        ib.core_req  = '0;
        ib.core_halt = '0;
        ib.core_pc   = '0;
        tick;
        tick;

        chk("rst a rom_en", 32'(ia.rom_en), 32'd0);
        chk("rst a rom_addr", 32'(ia.rom_addr), 32'd0);
        chk("rst a core_ins", ia.core_ins, 32'd0);
        chk("rst a core_av", 32'(ia.core_av), 32'd0);
        chk("rst a busy", 32'(ia.busy), 32'd0);
        chk("rst b rom_en", 32'(ib.rom_en), 32'd0);
        chk("rst b rom_addr", 32'(ib.rom_addr), 32'd0);
        chk("rst b core_ins", ib.core_ins, 32'd0);
        chk("rst b core_av", 32'(ib.core_av), 32'd0);
        chk("rst b busy", 32'(ib.busy), 32'd0);
        rst_n_a = 1'b1;
        rst_n_b = 1'b1;

        // Lockstep broadcast: all four cores at PC 0x10.
        ia.core_pc  = {4{8'h10}};
        ia.core_req = 4'b1111;
        tick;
        chk("t1 rom_en", 32'(ia.rom_en), 32'd1);
        chk("t1 rom_addr", 32'(ia.rom_addr), 32'h10);
        chk("t1 busy", 32'(ia.busy), 32'd1);
        tick;
        chk("t1 rom_en drop", 32'(ia.rom_en), 32'd0);
        chk("t1 av early", 32'(ia.core_av), 32'd0);
        tick;
        chk("t1 av", 32'(ia.core_av), 32'hF);
        chk("t1 ins", ia.core_ins, 32'hA5A5A5A5);
        ia.core_req = 4'b0000;
        tick;
        chk("t1 av pulse", 32'(ia.core_av), 32'd0);
        chk("t1 en count", 32'(en_cnt_a), 32'd1);

        // Lockstep waits for core 3, then issues once core 3 is halted.
        ia.core_pc  = {4{8'h22}};
        ia.core_req = 4'b0111;
        tick;
        tick;
        tick;
        chk("t2 no issue", 32'(en_cnt_a), 32'd1);
        chk("t2 idle", 32'(ia.busy), 32'd0);
        ia.core_halt = 4'b1000;
        tick;
        chk("t2 rom_en", 32'(ia.rom_en), 32'd1);
        chk("t2 rom_addr", 32'(ia.rom_addr), 32'h22);
        tick;
        tick;
        chk("t2 av", 32'(ia.core_av), 32'h7);
        chk("t2 ins", ia.core_ins, 32'hA5979797);
        ia.core_req  = 4'b0000;
        ia.core_halt = 4'b0000;
        tick;
        chk("t2 av pulse", 32'(ia.core_av), 32'd0);

        // Divergent PCs in round-robin order.
        ib.core_pc  = {8'h30, 8'h20, 8'h04, 8'h04};
        ib.core_req = 4'b1111;
        fetch_b("t3 f1", 8'h04, 4'b0011);
        fetch_b("t3 f2", 8'h20, 4'b0100);
        fetch_b("t3 f3", 8'h30, 4'b1000);

        // Single requester, ROM_LAT=3.
        ib.core_pc  = {8'h00, 8'h7F, 8'h00, 8'h00};
        ib.core_req = 4'b0100;
        fetch_b("t4", 8'h7F, 4'b0100);

        // Reset during WAIT aborts the fetch and clears rr_ptr.
        ib.core_pc  = {8'h00, 8'h00, 8'h40, 8'h00};
        ib.core_req = 4'b0010;
        n = 0;
        while (ib.rom_en !== 1'b1 && n < 20) begin
            tick;
            n++;
        end
        chk("t5 issue seen", 32'(ib.rom_en), 32'd1);
        tick;
        chk("t5 in flight", 32'(ib.busy), 32'd1);
        rst_n_b = 1'b0;
        #1;
        chk("t5 rst rom_en", 32'(ib.rom_en), 32'd0);
        chk("t5 rst av", 32'(ib.core_av), 32'd0);
        chk("t5 rst ins", ib.core_ins, 32'd0);
        chk("t5 rst busy", 32'(ib.busy), 32'd0);
        exp_ins_b   = '0;
        ib.core_req = 4'b0000;
        n = en_cnt_b;
        tick;
        tick;
        chk("t5 no av", 32'(ib.core_av), 32'd0);
        chk("t5 no en", 32'(en_cnt_b - n), 32'd0);
        ib.core_pc  = {8'h60, 8'h00, 8'h50, 8'h00};
        ib.core_req = 4'b1010;
        rst_n_b = 1'b1;
        fetch_b("t5 restart", 8'h50, 4'b0010);
        fetch_b("t5 next", 8'h60, 4'b1000);

        // Core 0 keeps renewing with new PCs; core 1 must not starve.
        ib.core_pc  = {8'h00, 8'h00, 8'h02, 8'h01};
        ib.core_req = 4'b0011;
        fetch_b("t6 f1", 8'h01, 4'b0001);
        ib.core_req[0]   = 1'b1;
        ib.core_pc[7:0]  = 8'h03;
        fetch_b("t6 f2", 8'h02, 4'b0010);
        fetch_b("t6 f3", 8'h03, 4'b0001);
        ib.core_req = 4'b0000;
        tick;
        chk("t6 av pulse", 32'(ib.core_av), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/imem_arbiter.md
Name: imem_arbiter

Overview:
- Parametrised successor to the fixed 4-core instruction-memory controller.
- Shares one single-port IROM among NCORES cores.
- Merges identical-PC requests into one broadcast fetch (lockstep case).
- Serves divergent PCs in round-robin order, excluding halted cores from every decision.
- Sits between the core array and the IROM in the multi-core top level.

Parameters:
- NCORES, 4, number of cores served (2..16).
- AW, 8, IROM address width.
- DW, 8, instruction width.
- ROM_LAT, 1, IROM read latency in Clk edges from rom_en to valid rom_data (1..4).
- LOCKSTEP, 1, 1 = issue only when every non-halted core is requesting; 0 = issue as soon as any core requests.

Ports:
- Clk  in  1  system clock; all sequential logic on negedge Clk.
- Rst_n  in  1  asynchronous active-low reset.
- core_req  in  NCORES  per-core fetch request (level, held until its core_av pulse).
- core_halt  in  NCORES  per-core halted flag; a halted core is ignored entirely.
- core_pc  in  NCORES*AW  packed PCs; core i at [i*AW +: AW].
- rom_data  in  DW  IROM read data.
- rom_en  out  1  IROM read enable.
- rom_addr  out  AW  IROM read address.
- core_ins  out  NCORES*DW  packed per-core instruction registers.
- core_av  out  NCORES  per-core one-cycle "instruction valid" pulse.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (async, Rst_n low): state = IDLE; rom_en = 0; rom_addr = 0; core_ins = 0; core_av = 0; rr_ptr = 0; wait counter = 0; grant mask = 0.
- active = core_req & ~core_halt.
- States: IDLE, ISSUE, WAIT, DELIVER.
- IDLE:
  - core_av = 0; rom_en = 0.
  - Issue condition, LOCKSTEP=1: active == ~core_halt and ~core_halt != 0.
  - Issue condition, LOCKSTEP=0: active != 0.
  - On the issue condition, the leader is the first set bit of active, searching upward from rr_ptr with wrap-around.
  - grant mask = all active cores whose core_pc equals the leader's PC.
  - rom_addr = leader PC; rom_en = 1; go to ISSUE.
  - All cores halted: stay in IDLE forever, no rom_en.
- ISSUE:
  - rom_en = 0; counter = ROM_LAT-1.
  - If ROM_LAT == 1, go to DELIVER; else go to WAIT.
- WAIT: decrement counter; go to DELIVER when it reaches 0.
- DELIVER:
  - For every granted core i: core_ins[i] = rom_data and core_av[i] = 1 for exactly this cycle.
  - Non-granted core_ins slots keep their old value.
  - rr_ptr = (leader + 1) mod NCORES.
  - Go to IDLE.
- Latency: issue edge to core_av edge = ROM_LAT + 1 negedges. Minimum inter-fetch spacing is ROM_LAT + 2 edges.
- Cores must drop or renew req on the posedge after seeing core_av. The IDLE cycle after DELIVER samples the renewed request.
- Grant mask and leader PC are latched at issue. core_pc or core_req changes after issue do not alter the in-flight fetch.
- Halt of a granted core mid-fetch:
  - That core's slot is still written in DELIVER.
  - Its av is suppressed if core_halt is high at DELIVER.
- LOCKSTEP=1, all PCs equal: a single fetch serves every core; degenerates to the legacy controller behaviour.
- Divergent PCs: one fetch per distinct PC group. Order is round-robin from rr_ptr, giving no starvation. Bound: every requester is served within NCORES fetches.
- Reset asserted mid-fetch: immediate return to reset values; no av is emitted for the aborted fetch.

Decomposition:
- Shared package imem_pkg:
  - state encodings IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, DELIVER=2'd3;
  - ROM_LAT upper bound constant.
- One natural sub-module rr_pick: combinational round-robin first-set-bit finder (inputs: mask, ptr; outputs: index, found).
- The top level instantiates rr_pick and the PC-match compare loop.

Test Plan:
1. NCORES=4, LOCKSTEP=1, ROM_LAT=1, all req, PCs all 8'h10, rom_data=8'hA5 -> one rom_en with rom_addr=8'h10; core_av=4'b1111 two edges later; all core_ins=8'hA5.
2. LOCKSTEP=1, core 3 req low, others req -> no rom_en until core 3 requests. With core_halt=4'b1000 instead -> fetch issues, core_av=4'b0111.
3. LOCKSTEP=0, PCs {0x04,0x04,0x20,0x30}, all req, rr_ptr=0 -> three fetches in order 0x04 (av 4'b0011), 0x20 (4'b0100), 0x30 (4'b1000).
4. ROM_LAT=3, single requester core 2, PC 0x7F -> rom_en once; core_av[2] exactly 4 edges after the issue edge; busy high for those 4 edges.
5. Rst_n pulled low during WAIT -> rom_en=0, core_av=0, core_ins=0 immediately. After release, the first fetch restarts from rr_ptr=0.
6. LOCKSTEP=0, core 0 requests continuously with a new PC each time, core 1 requests once -> core 1 is served no later than the second fetch (no starvation).
